// File: rtl/opsel_pkg.sv
// Shared types and helpers for the operand selector: occupancy states, constant-slot defaults
// and the select decode.
package opsel_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } opsel_state_e;

    typedef enum logic [1:0] {
        SelConst0,
        SelConst1,
        SelBus,
        SelNone
    } opsel_src_e;

    localparam int unsigned OPSEL_CONST0 = 12;
    localparam int unsigned OPSEL_CONST1 = 1;

    // Classifies a select value; anything at or beyond num_in is out of range.
    function automatic opsel_src_e opsel_decode(int unsigned sel, int unsigned num_in);
        if (sel >= num_in) begin
            return SelNone;
        end else if (sel == 0) begin
            return SelConst0;
        end else if (sel == 1) begin
            return SelConst1;
        end
        return SelBus;
    endfunction

endpackage

// File: rtl/operand_select_pipe_if.sv
// Handshake and data bundle between the operand producer, the selector pipe and its consumer.
interface operand_select_pipe_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 3
);
    logic [(NUM_IN-2)*WIDTH-1:0] Input;
    logic [SEL_W-1:0]            S;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic [WIDTH-1:0]            O;
    logic                        out_valid;
    logic                        out_ready;
    logic                        sel_err;

    modport master (
        output Input, S, in_valid, flush, out_ready,
        input  in_ready, O, out_valid, sel_err
    );

    modport slave (
        input  Input, S, in_valid, flush, out_ready,
        output in_ready, O, out_valid, sel_err
    );

endinterface

// File: rtl/opsel_skid.sv
// Two-entry valid/ready skid buffer with synchronous flush; in_ready is purely state-derived.
module opsel_skid
    import opsel_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    opsel_state_e     state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             pop;

    assign in_ready_o  = (state_q != StFull);
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = out_valid_o ? head_q : '0;
    assign accept      = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_d  = in_data_i;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    head_d = in_data_i;
                end else if (accept) begin
                    skid_d  = in_data_i;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Stale data left in head/skid is harmless: out_data_o is masked while empty.
        if (flush_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/operand_select_pipe.sv
// Registered N-way operand selector feeding a 2-entry skid buffer.
// Optional OPSEL_RANGE_CHECK_EN stores and reports an out-of-range select error per word.
module operand_select_pipe
    import opsel_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned CONST0 = OPSEL_CONST0,
    parameter int unsigned CONST1 = OPSEL_CONST1
) (
    input logic                  CLK,
    input logic                  Reset,
    operand_select_pipe_if.slave bus
);

    localparam logic [WIDTH-1:0] C0 = WIDTH'(CONST0);
    localparam logic [WIDTH-1:0] C1 = WIDTH'(CONST1);

    if (WIDTH < 4 || NUM_IN < 3 || NUM_IN > 8 || (2 ** SEL_W) < NUM_IN) begin : g_bad_params
        $error("operand_select_pipe: illegal WIDTH/NUM_IN/SEL_W combination");
    end

    opsel_src_e       src;
    int unsigned      sel_idx;
    logic [WIDTH-1:0] word;
    logic             range_err;
    logic [WIDTH:0]   in_word;
    logic [WIDTH:0]   out_word;

    always_comb begin
        sel_idx   = 32'(bus.S);
        src       = opsel_decode(sel_idx, NUM_IN);
        word      = '0;
        range_err = 1'b0;
        unique case (src)
            SelConst0: word = C0;
            SelConst1: word = C1;
            SelBus: begin
                for (int unsigned k = 2; k < NUM_IN; k++) begin
                    if (sel_idx == k) begin
                        word = bus.Input[(k-2)*WIDTH +: WIDTH];
                    end
                end
            end
            default: range_err = 1'b1;
        endcase
    end

`ifdef OPSEL_RANGE_CHECK_EN
    assign in_word     = {range_err, word};
    assign bus.sel_err = bus.out_valid & out_word[WIDTH];
`else
    logic unused_err;
    assign in_word     = {1'b0, word};
    assign bus.sel_err = 1'b0;
    assign unused_err  = out_word[WIDTH] ^ range_err;
`endif

    assign bus.O = out_word[WIDTH-1:0];

    opsel_skid #(
        .WIDTH(WIDTH + 1)
    ) u_skid (
        .clk_i      (CLK),
        .rst_i      (Reset),
        .flush_i    (bus.flush),
        .in_valid_i (bus.in_valid),
        .in_ready_o (bus.in_ready),
        .in_data_i  (in_word),
        .out_valid_o(bus.out_valid),
        .out_ready_i(bus.out_ready),
        .out_data_o (out_word)
    );

endmodule

// File: tb/tb_operand_select_pipe.sv
// Self-checking bench for operand_select_pipe: directed scenarios plus a randomised scoreboard run.
module tb_operand_select_pipe;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned SEL_W  = 3;

`ifdef OPSEL_RANGE_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Reset;

    always #5 CLK = ~CLK;

    operand_select_pipe_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    operand_select_pipe #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W)
    ) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] sb[$];

    // Expected {sel_err, O} for a word accepted with the given select and bus.
    function automatic logic [WIDTH:0] model(logic [SEL_W-1:0] s, logic [31:0] in);
        case (s)
            3'd0:    return {1'b0, 16'd12};
            3'd1:    return {1'b0, 16'd1};
            3'd2:    return {1'b0, in[15:0]};
            3'd3:    return {1'b0, in[31:16]};
            default: return {ERR_EN, 16'd0};
        endcase
    endfunction

    task automatic drive(input logic iv, input logic [SEL_W-1:0] s, input logic [31:0] in,
                         input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.S         = s;
        bus.Input     = in;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        checks++;
        if (bus.O !== 16'd0) begin
            errors++; $display("FAIL reset_O: got %h want 0", bus.O);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.sel_err !== 1'b0) begin
            errors++; $display("FAIL reset_sel_err: got %b want 0", bus.sel_err);
        end
    endtask

    task automatic test_select();
        logic [WIDTH:0] want;
        logic exp_valid, exp_ready;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            drive(i < 3, 3'(i), 32'h0000_0007, 1'b1, 1'b0);
            exp_valid = sb.size() > 0;
            exp_ready = sb.size() < 2;
            checks++;
            if (bus.out_valid !== exp_valid) begin
                errors++;
                $display("FAIL select_out_valid[%0d]: got %b want %b", i, bus.out_valid, exp_valid);
            end
            checks++;
            if (bus.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL select_in_ready[%0d]: got %b want %b", i, bus.in_ready, exp_ready);
            end
            if (exp_valid && bus.out_ready) begin
                want = sb.pop_front();
                checks++;
                if ({bus.sel_err, bus.O} !== want) begin
                    errors++;
                    $display("FAIL select_data[%0d]: got %h want %h", i, {bus.sel_err, bus.O},
                             want);
                end
            end
            if (bus.in_valid && exp_ready) sb.push_back(model(bus.S, bus.Input));
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH:0] want;
        logic exp_valid, exp_ready;
        logic       iv_t[6]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0] s_t[6]    = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
        logic       ordy_t[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            drive(iv_t[i], s_t[i], 32'h0000_0007, ordy_t[i], 1'b0);
            exp_valid = sb.size() > 0;
            exp_ready = sb.size() < 2;
            checks++;
            if (bus.out_valid !== exp_valid) begin
                errors++;
                $display("FAIL bp_out_valid[%0d]: got %b want %b", i, bus.out_valid, exp_valid);
            end
            checks++;
            if (bus.in_ready !== exp_ready) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b want %b", i, bus.in_ready, exp_ready);
            end
            if (exp_valid) begin
                // Head must be visible and stable whether or not it is taken this cycle.
                want = bus.out_ready ? sb.pop_front() : sb[0];
                checks++;
                if ({bus.sel_err, bus.O} !== want) begin
                    errors++;
                    $display("FAIL bp_data[%0d]: got %h want %h", i, {bus.sel_err, bus.O}, want);
                end
            end
            if (bus.in_valid && exp_ready) sb.push_back(model(bus.S, bus.Input));
        end
    endtask

    task automatic test_range();
        @(negedge CLK);
        drive(1'b1, 3'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge CLK);
        drive(1'b1, 3'd3, 32'hABCD_0000, 1'b1, 1'b0);
        checks++;
        if ({bus.out_valid, bus.sel_err, bus.O} !== {1'b1, ERR_EN, 16'd0}) begin
            errors++;
            $display("FAIL range_oob: got v=%b e=%b O=%h want v=1 e=%b O=0", bus.out_valid,
                     bus.sel_err, bus.O, ERR_EN);
        end
        @(negedge CLK);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.out_valid, bus.sel_err, bus.O} !== {1'b1, 1'b0, 16'hABCD}) begin
            errors++;
            $display("FAIL range_inrange: got v=%b e=%b O=%h want v=1 e=0 O=abcd",
                     bus.out_valid, bus.sel_err, bus.O);
        end
        @(negedge CLK);
        checks++;
        if ({bus.out_valid, bus.sel_err} !== 2'b00) begin
            errors++;
            $display("FAIL range_drain: got v=%b e=%b want 0 0", bus.out_valid, bus.sel_err);
        end
    endtask

    task automatic test_flush();
        @(negedge CLK);
        drive(1'b1, 3'd1, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        drive(1'b1, 3'd3, 32'h1234_0000, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_full: got v=%b r=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        drive(1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
        @(negedge CLK);
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.O} !== {2'b01, 16'd0}) begin
            errors++;
            $display("FAIL flush_from_full: got v=%b r=%b O=%h want 0 1 0", bus.out_valid,
                     bus.in_ready, bus.O);
        end
        // Flush while empty and ready: the offered word must be dropped.
        drive(1'b1, 3'd0, 32'h0, 1'b0, 1'b1);
        @(negedge CLK);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: got v=%b want 0", bus.out_valid);
        end
        drive(1'b1, 3'd2, 32'h0000_0007, 1'b1, 1'b0);
        @(negedge CLK);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.out_valid, bus.O} !== {1'b1, 16'd7}) begin
            errors++;
            $display("FAIL flush_next_word: got v=%b O=%h want 1 0007", bus.out_valid, bus.O);
        end
        @(negedge CLK);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain: got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        drive(1'b1, 3'd0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        drive(1'b1, 3'd2, 32'h0000_0007, 1'b0, 1'b0);
        @(negedge CLK);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_full: got r=%b want 0", bus.in_ready);
        end
        Reset = 1'b1;
        drive(1'b1, 3'd1, 32'h0, 1'b1, 1'b0);
        @(negedge CLK);
        drive(1'b1, 3'd1, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        Reset = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.O} !== {2'b01, 16'd0}) begin
            errors++;
            $display("FAIL rstmid_state: got v=%b r=%b O=%h want 0 1 0", bus.out_valid,
                     bus.in_ready, bus.O);
        end
        drive(1'b1, 3'd1, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({bus.out_valid, bus.O} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL rstmid_first: got v=%b O=%h want 1 0001", bus.out_valid, bus.O);
        end
        @(negedge CLK);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drain: got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [WIDTH:0] want;
        logic exp_valid, exp_ready;
        int drain;
        sb.delete();
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
            exp_valid = sb.size() > 0;
            exp_ready = sb.size() < 2;
            checks++;
            if ({bus.out_valid, bus.in_ready} !== {exp_valid, exp_ready}) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got v=%b r=%b want v=%b r=%b", i,
                         bus.out_valid, bus.in_ready, exp_valid, exp_ready);
            end
            if (bus.flush) begin
                sb.delete();
            end else begin
                if (exp_valid) begin
                    want = bus.out_ready ? sb.pop_front() : sb[0];
                    checks++;
                    if ({bus.sel_err, bus.O} !== want) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: got %h want %h", i,
                                 {bus.sel_err, bus.O}, want);
                    end
                end
                if (bus.in_valid && exp_ready) sb.push_back(model(bus.S, bus.Input));
            end
        end
        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(negedge CLK);
            drive(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
            if (bus.out_valid === 1'b1) begin
                want = sb.pop_front();
                checks++;
                if ({bus.sel_err, bus.O} !== want) begin
                    errors++;
                    $display("FAIL rand_drain_data: got %h want %h", {bus.sel_err, bus.O}, want);
                end
            end
            drain++;
        end
        @(negedge CLK);
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_final: got left=%0d v=%b want left=0 v=0", sb.size(),
                     bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_backpressure();
        test_range();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
